// File: rtl/ultrasonic_scan_scheduler_if.sv
// Sample bus of the ultrasonic scan scheduler: one tagged range sample per ping.
// master drives the bus (the scheduler), slave consumes it.
interface ultrasonic_scan_scheduler_if #(
    parameter int NUM_SENSORS = 4
);
    localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    logic            sample_valid;
    logic [ID_W-1:0] sample_id;
    logic [15:0]     sample_us;
    logic            sample_timeout;

    modport master (
        output sample_valid,
        output sample_id,
        output sample_us,
        output sample_timeout
    );

    modport slave (
        input sample_valid,
        input sample_id,
        input sample_us,
        input sample_timeout
    );
endinterface

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin ranging controller for HC-SR04-style ultrasonic sensors that
// share one echo-measurement datapath. Fires one sensor at a time, measures
// its echo width in microseconds, enforces echo timeout and inter-ping guard
// time, publishes one tagged sample per ping and keeps per-sensor crash flags.
//
// Optional feature macro: PROX_CRASH_HYST_EN (crash flag release hysteresis).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | scanning stopped, waiting for enable
// S_TRIG    | trigger[idx] high for TRIG_CYCLES clocks
// S_WAIT_RISE| waiting for echo rise, bounded by ECHO_TIMEOUT_US ticks
// S_MEASURE | echo high, us_cnt counts ticks until fall or timeout
// S_GUARD   | quiet time GUARD_US ticks, then advance idx
module ultrasonic_scan_scheduler #(
    parameter int NUM_SENSORS     = 4,
    parameter int TICK_DIV        = 100,
    parameter int TRIG_CYCLES     = 1000,
    parameter int ECHO_TIMEOUT_US = 30000,
    parameter int GUARD_US        = 10000,
    parameter int CRASH_US        = 880,
    parameter int HYST_US         = 120
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic [NUM_SENSORS-1:0] crash,
    output logic                   any_crash,
    ultrasonic_scan_scheduler_if.master smp
);
    localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (NUM_SENSORS < 1 || NUM_SENSORS > 8 || TICK_DIV < 1 || TRIG_CYCLES < 1 ||
        ECHO_TIMEOUT_US < 1 || ECHO_TIMEOUT_US >= 65535 || GUARD_US < 1 ||
        CRASH_US < 0 || HYST_US < 0 || CRASH_US + HYST_US > 65535) begin : g_param_check
        $error("ultrasonic_scan_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GUARD
    } state_t;

    state_t                 state, next_state;
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_d;
    logic [TW-1:0]          tick_cnt;
    logic [31:0]            timer;
    logic [15:0]            us_cnt;
    logic [ID_W-1:0]        idx, idx_next;
    logic [NUM_SENSORS-1:0] trig_next;

    logic tick, timer_tc, us_max, rise, fall, entry, emit, emit_to;
    logic [15:0] emit_us;

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign timer_tc = (timer == 32'd0);
    assign us_max   = (us_cnt >= 16'(ECHO_TIMEOUT_US));
    assign rise     = echo_s2[idx] & ~echo_d[idx];
    assign fall     = ~echo_s2[idx] & echo_d[idx];
    assign entry    = (next_state != state);
    assign emit_us  = emit_to ? 16'hFFFF : us_cnt;
    assign any_crash = |crash;

    // Two-flop synchronizer plus previous-cycle copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic; rise wins over a timeout landing in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (enable) next_state = S_TRIG;
            S_TRIG:      if (timer_tc) next_state = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (rise)                  next_state = S_MEASURE;
                else if (tick && timer_tc) next_state = S_GUARD;
            end
            S_MEASURE:   if (fall || us_max) next_state = S_GUARD;
            S_GUARD:     if (tick && timer_tc) next_state = enable ? S_TRIG : S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // FSM outputs: sample emission, sensor advance and next trigger pattern.
    always_comb begin
        emit      = 1'b0;
        emit_to   = 1'b0;
        idx_next  = idx;
        trig_next = '0;
        case (state)
            S_WAIT_RISE: begin
                if (!rise && tick && timer_tc) begin
                    emit    = 1'b1;
                    emit_to = 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall) begin
                    emit = 1'b1;
                end else if (us_max) begin
                    emit    = 1'b1;
                    emit_to = 1'b1;
                end
            end
            S_GUARD: begin
                if (tick && timer_tc)
                    idx_next = (idx == ID_W'(NUM_SENSORS - 1)) ? '0 : idx + 1'b1;
            end
            default: ;
        endcase
        if (next_state == S_TRIG)
            trig_next = NUM_SENSORS'(1) << idx_next;
    end

    // Microsecond tick divider; restarted on entry to the tick-timed states
    // so each phase counts whole ticks from its own start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (entry && (next_state == S_WAIT_RISE || next_state == S_MEASURE ||
                           next_state == S_GUARD))
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Phase down-counter: trigger width in clocks, rise timeout and guard in ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (entry) begin
            case (next_state)
                S_TRIG:      timer <= 32'(TRIG_CYCLES - 1);
                S_WAIT_RISE: timer <= 32'(ECHO_TIMEOUT_US - 1);
                S_GUARD:     timer <= 32'(GUARD_US - 1);
                default:     timer <= '0;
            endcase
        end else if (!timer_tc) begin
            if (state == S_TRIG)
                timer <= timer - 32'd1;
            else if ((state == S_WAIT_RISE || state == S_GUARD) && tick)
                timer <= timer - 32'd1;
        end
    end

    // Echo width counter and current sensor index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt <= '0;
            idx    <= '0;
        end else begin
            idx <= idx_next;
            if (entry && next_state == S_MEASURE)
                us_cnt <= '0;
            else if (state == S_MEASURE && tick && !us_max)
                us_cnt <= us_cnt + 16'd1;
        end
    end

    // Registered outputs: trigger lines, sample bus and crash flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger            <= '0;
            smp.sample_valid   <= 1'b0;
            smp.sample_id      <= '0;
            smp.sample_us      <= '0;
            smp.sample_timeout <= 1'b0;
            crash              <= '0;
        end else begin
            trigger          <= trig_next;
            smp.sample_valid <= emit;
            if (emit) begin
                smp.sample_id      <= idx;
                smp.sample_us      <= emit_us;
                smp.sample_timeout <= emit_to;
                if (emit_to) begin
                    crash[idx] <= 1'b0;
                end else begin
`ifdef PROX_CRASH_HYST_EN
                    // Between the set and release thresholds the flag holds.
                    if (emit_us <= 16'(CRASH_US))
                        crash[idx] <= 1'b1;
                    else if (emit_us > 16'(CRASH_US + HYST_US))
                        crash[idx] <= 1'b0;
`else
                    crash[idx] <= (emit_us <= 16'(CRASH_US));
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for ultrasonic_scan_scheduler with scaled-down timing
// parameters so a full scan round fits in a few thousand clocks.
module tb_ultrasonic_scan_scheduler;
    localparam int NS    = 4;
    localparam int TD    = 4;
    localparam int TRIGC = 10;
    localparam int TO_US = 300;
    localparam int GD_US = 20;
    localparam int CR_US = 50;
    localparam int HY_US = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trigger;
    logic [NS-1:0] crash;
    logic          any_crash;

    ultrasonic_scan_scheduler_if #(.NUM_SENSORS(NS)) smp_if ();

    ultrasonic_scan_scheduler #(
        .NUM_SENSORS(NS), .TICK_DIV(TD), .TRIG_CYCLES(TRIGC),
        .ECHO_TIMEOUT_US(TO_US), .GUARD_US(GD_US), .CRASH_US(CR_US), .HYST_US(HY_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
        .trigger(trigger), .crash(crash), .any_crash(any_crash), .smp(smp_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp, input int tol = 0);
        logic [31:0] diff;
        tests++;
        diff = (obs > exp) ? obs - exp : exp - obs;
        if ((^obs === 1'bx) || diff > 32'(tol)) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d tol %0d", tag, obs, obs, exp, tol);
        end
    endtask

    // Trigger monitor: order of pings, pulse lengths, one-hot violations.
    logic [NS-1:0] trig_prev = '0;
    int hi_cnt = 0;
    int onehot_viol = 0;
    int trig_log[$];
    int len_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            trig_prev = '0;
            hi_cnt = 0;
        end else begin
            if ($countones(trigger) > 1) onehot_viol++;
            if (trigger != '0) begin
                if (trig_prev == '0) begin
                    for (int i = 0; i < NS; i++) if (trigger[i]) trig_log.push_back(i);
                    hi_cnt = 1;
                end else begin
                    hi_cnt++;
                end
            end else if (trig_prev != '0) begin
                len_log.push_back(hi_cnt);
            end
            trig_prev = trigger;
        end
    end

    int            s_id, s_us, s_to;
    logic [NS-1:0] s_crash;
    logic          s_any;

    // One ping on sensor s: echo of w us (0 = none) 10 us after trigger fall.
    task automatic ping(input int s, input int w, input bit drop_en);
        int n;
        bit got;
        n = 0;
        while (!trigger[s] && n < 4000) begin @(negedge clk); n++; end
        if (!trigger[s]) begin
            check($sformatf("trig_wait_s%0d", s), 32'(trigger), 32'(1 << s));
            return;
        end
        n = 0;
        while (trigger != '0 && n < 200) begin @(negedge clk); n++; end
        repeat (10 * TD) @(negedge clk);
        if (w > 0) begin
            echo[s] = 1'b1;
            if (drop_en) begin
                repeat ((w * TD) / 2) @(negedge clk);
                enable = 1'b0;
                repeat (w * TD - (w * TD) / 2) @(negedge clk);
            end else begin
                repeat (w * TD) @(negedge clk);
            end
            echo[s] = 1'b0;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (smp_if.sample_valid) begin
                got = 1'b1;
                s_id = int'(smp_if.sample_id);
                s_us = int'(smp_if.sample_us);
                s_to = int'(smp_if.sample_timeout);
                s_crash = crash;
                s_any = any_crash;
            end
        end
        check($sformatf("sample_seen_s%0d", s), 32'(got), 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_trigger"}, 32'(trigger), 0);
        check({pfx, "_valid"}, 32'(smp_if.sample_valid), 0);
        check({pfx, "_id"}, 32'(smp_if.sample_id), 0);
        check({pfx, "_us"}, 32'(smp_if.sample_us), 0);
        check({pfx, "_timeout"}, 32'(smp_if.sample_timeout), 0);
        check({pfx, "_crash"}, 32'(crash), 0);
        check({pfx, "_any"}, 32'(any_crash), 0);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n, cnt;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_trig", 32'(trigger), 0);

        enable = 1'b1;
        ping(0, 20, 1'b0);
        check("s0_id", 32'(s_id), 0);
        check("s0_us", 32'(s_us), 20, 1);
        check("s0_to", 32'(s_to), 0);
        check("s0_crash0", 32'(s_crash[0]), 1);
        check("s0_any", 32'(s_any), 1);

        ping(1, 100, 1'b0);
        check("s1_id", 32'(s_id), 1);
        check("s1_us", 32'(s_us), 100, 1);
        check("s1_crash1", 32'(s_crash[1]), 0);

        ping(2, 0, 1'b0);
        check("s2_id", 32'(s_id), 2);
        check("s2_us", 32'(s_us), 32'hFFFF);
        check("s2_to", 32'(s_to), 1);
        check("s2_crash2", 32'(s_crash[2]), 0);

        ping(3, 40, 1'b0);
        check("s3_crash", 32'(s_crash), 32'b1001);

        ping(0, 200, 1'b0);
        check("s0b_us", 32'(s_us), 200, 1);
        check("s0b_crash", 32'(s_crash), 32'b1000);
        repeat (5) @(negedge clk);
        check("hold_us", 32'(smp_if.sample_us), 200, 1);
        check("trig_count", 32'(trig_log.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < trig_log.size())
                check($sformatf("order_%0d", i), 32'(trig_log[i]), 32'(exp_order[i]));
            if (i < len_log.size())
                check($sformatf("trig_len_%0d", i), 32'(len_log[i]), TRIGC);
        end

        // Enable dropped mid-measure: ping completes, then scanning stops.
        ping(1, 60, 1'b1);
        check("drop_id", 32'(s_id), 1);
        check("drop_us", 32'(s_us), 60, 1);
        cnt = trig_log.size();
        repeat (GD_US * TD + 300) @(negedge clk);
        check("drop_no_trig", 32'(trig_log.size()), 32'(cnt));
        enable = 1'b1;
        n = 0;
        while (trigger == '0 && n < 100) begin @(negedge clk); n++; end
        check("reenable_trig", 32'(trigger), 32'b0100);

        // Reset in the middle of a measurement on sensor 2.
        n = 0;
        while (trigger != '0 && n < 200) begin @(negedge clk); n++; end
        repeat (10 * TD) @(negedge clk);
        echo[2] = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        echo[2] = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (trigger == '0 && n < 100) begin @(negedge clk); n++; end
        check("post_rst_trig", 32'(trigger), 32'b0001);

        // Threshold behaviour on sensor 0.
        ping(0, 45, 1'b0);
        check("thr45_crash0", 32'(s_crash[0]), 1);
        ping(1, 5, 1'b0);
        ping(2, 5, 1'b0);
        ping(3, 5, 1'b0);
        ping(0, 55, 1'b0);
`ifdef PROX_CRASH_HYST_EN
        check("hys55_crash0", 32'(s_crash[0]), 1);
        ping(1, 5, 1'b0);
        ping(2, 5, 1'b0);
        ping(3, 5, 1'b0);
        ping(0, 65, 1'b0);
        check("hys65_crash0", 32'(s_crash[0]), 0);
`else
        check("thr55_crash0", 32'(s_crash[0]), 0);
`endif
        check("onehot_viol", 32'(onehot_viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ultrasonic_scan_scheduler.md
# ultrasonic_scan_scheduler

Round-robin ranging controller for up to `NUM_SENSORS` HC-SR04-style ultrasonic sensors sharing one measurement datapath. It fires one sensor at a time, measures that sensor's echo pulse width in microseconds, and enforces echo timeouts and an inter-ping guard time so sensors do not hear each other's echoes. It publishes one tagged sample per ping and maintains per-sensor crash flags for the motor controller.

## Interface
- `NUM_SENSORS`, 4: number of sensors scanned; valid range 1..8.
- `TICK_DIV`, 100: `clk` cycles per 1 µs tick (100 MHz board clock).
- `TRIG_CYCLES`, 1000: trigger pulse width in `clk` cycles (10 µs).
- `ECHO_TIMEOUT_US`, 30000: maximum wait for echo rise, and maximum echo width.
- `GUARD_US`, 10000: quiet time after each ping before the next trigger.
- `CRASH_US`, 880: echo width at or below which `crash` sets (≈15 cm).
- `HYST_US`, 120: release margin; used only when `PROX_CRASH_HYST_EN` is defined.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: scanning enabled.
- `echo` in `NUM_SENSORS`: raw echo lines, asynchronous to `clk`.
- `trigger` out `NUM_SENSORS`: trigger lines; at most one bit high at any time.
- `sample_valid` out 1: one-cycle strobe, new sample.
- `sample_id` out `$clog2(NUM_SENSORS)` (min 1): sensor index of the sample.
- `sample_us` out 16: echo width in µs; 0xFFFF on timeout.
- `sample_timeout` out 1: sample ended by timeout.
- `crash` out `NUM_SENSORS`: per-sensor obstacle-too-close flags.
- `any_crash` out 1: OR of `crash`.

## Operation
- Each `echo` bit passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its previous-cycle copy.
- The µs tick is a counter modulo `TICK_DIV`. It is cleared on entry to WAIT_RISE and again on the detected echo rise, so width is counted from the rise.
- FSM states and transitions:
  - **IDLE**: leave when `enable`=1, going to TRIG for sensor `idx`.
  - **TRIG**: `trigger[idx]`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE.
  - **WAIT_RISE**: on a rising edge of `echo[idx]`, go to MEASURE with `us_cnt`=0. If `ECHO_TIMEOUT_US` ticks elapse first, emit a timeout sample and go to GUARD.
  - **MEASURE**: `us_cnt` increments on each tick. On a falling edge, emit `us_cnt` and go to GUARD. If `us_cnt` reaches `ECHO_TIMEOUT_US`, emit a timeout sample and go to GUARD.
  - **GUARD**: wait `GUARD_US` ticks. Then `idx` advances, wrapping from `NUM_SENSORS-1` to 0. Go to TRIG if `enable`=1, otherwise IDLE.
- An echo already high at WAIT_RISE entry is not a rise. A rise is required.
- Deasserting `enable` mid-ping does not abort the ping. The current ping completes through GUARD, then the FSM goes to IDLE. `idx` is retained.
- Timeout sample: `sample_us`=0xFFFF, `sample_timeout`=1, `crash[id]` cleared.
- Valid sample: `crash[id]` = (`sample_us` ≤ `CRASH_US`). Other sensors' flags are unchanged.
- `us_cnt` is 16 bits. All compares are unsigned. `ECHO_TIMEOUT_US` must be < 0xFFFF.

## Timing
- Reset values: `trigger`=0, `sample_valid`=0, `sample_id`=0, `sample_us`=0, `sample_timeout`=0, `crash`=0, `any_crash`=0. FSM resets to IDLE, `idx`=0, all counters 0.
- `trigger` rises 1 cycle after IDLE/GUARD exit and is high for exactly `TRIG_CYCLES` cycles.
- Latency from a raw `echo` fall to `sample_valid` is 3 cycles: 2 synchronizer cycles plus 1 registered output.
- `sample_id`, `sample_us` and `sample_timeout` update in the same cycle as `sample_valid` and hold until the next sample.
- `crash` updates in the `sample_valid` cycle. `any_crash` is combinational from the `crash` registers.
- Measured width is the true width in µs ±1 tick.
- Pings start no closer than `TRIG_CYCLES` + `GUARD_US`·`TICK_DIV` cycles apart.

## Configuration
- `PROX_CRASH_HYST_EN` defined: `crash[id]` sets when `sample_us` ≤ `CRASH_US`. Once set, it clears only on a timeout or when `sample_us` > `CRASH_US`+`HYST_US`. Values in between hold the previous state.
- Undefined: single threshold, exactly as described in Operation. `HYST_US` is ignored.

## Test plan
- Reset mid-MEASURE (`rst_n` low for 1 cycle): all outputs return to reset values at once; after release with `enable`=1 the next trigger is `trigger[0]`.
- Defaults, `enable`=1, sensor 0 echo high 500 µs starting 200 µs after the trigger fall → `sample_id`=0, `sample_us`=500±1, `crash[0]`=1, `any_crash`=1.
- Sensor 1 echo 2000 µs → `sample_us`=2000±1, `crash[1]`=0. Then sensor 2 gets no echo → after 30000 µs `sample_us`=0xFFFF, `sample_timeout`=1, `crash[2]`=0.
- `NUM_SENSORS`=4 with a 1 ms echo on every sensor → trigger order 0,1,2,3,0; `trigger` is one-hot or zero throughout; each trigger is high for 1000 cycles.
- `enable` dropped during MEASURE on sensor 1 → sample for sensor 1 is still emitted; FSM reaches IDLE after GUARD; no further triggers; re-enabling fires sensor 2.
- With `PROX_CRASH_HYST_EN`: echo widths 800, 950, 1100 µs on sensor 0 → `crash[0]` = 1, 1, 0.
